// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide, start/busy/valid handshake.
// Optional MULDIV_FAST_MUL_EN: multiply ops finish in one cycle through a full-width multiplier.
module muldiv_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] srcA_i,
    input  logic [DATA_WIDTH-1:0] srcB_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [W-1:0]           hi_q, lo_q, b_q, result_q;
    logic [2:0]             op_q;
    logic                   sign_q;
    logic                   accept, fin;

    // Operand decode: signedness, magnitudes and the divide special cases
    logic         sgn_a, sgn_b, neg_a, neg_b, div_zero, ovf, imm;
    logic [W-1:0] mag_a, mag_b, imm_res;

    assign sgn_a    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    assign sgn_b    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    assign neg_a    = sgn_a & srcA_i[W-1];
    assign neg_b    = sgn_b & srcB_i[W-1];
    assign mag_a    = neg_a ? -srcA_i : srcA_i;
    assign mag_b    = neg_b ? -srcB_i : srcB_i;
    assign div_zero = op_i[2] && (srcB_i == '0);
    assign ovf      = op_i[2] && !op_i[0] && (srcA_i == {1'b1, {(W-1){1'b0}}}) && (srcB_i == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] ext_a, ext_b, fprod;
    assign ext_a   = {{W{neg_a}}, srcA_i};
    assign ext_b   = {{W{neg_b}}, srcB_i};
    assign fprod   = ext_a * ext_b;
    assign imm     = div_zero || ovf || !op_i[2];
    assign imm_res = div_zero ? (op_i[1] ? srcA_i : '1) :
                     ovf      ? (op_i[1] ? '0 : srcA_i) :
                     (op_i[1:0] == 2'b00) ? fprod[W-1:0] : fprod[2*W-1:W];
`else
    assign imm     = div_zero || ovf;
    assign imm_res = div_zero ? (op_i[1] ? srcA_i : '1) : (op_i[1] ? '0 : srcA_i);
`endif

    // One iteration: restoring divide step or shift-add multiply step
    logic [W:0]     trial, sum;
    logic           ge;
    logic [W-1:0]   diff, hi_n, lo_n, dv, dv_f, calc_res;
    logic [2*W-1:0] prod, prod_f;

    assign trial = {hi_q, lo_q[W-1]};
    assign ge    = trial >= {1'b0, b_q};
    assign diff  = trial[W-1:0] - b_q;
    assign sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

    always_comb begin
        if (op_q[2]) begin
            hi_n = ge ? diff : trial[W-1:0];
            lo_n = {lo_q[W-2:0], ge};
        end else begin
            hi_n = sum[W:1];
            lo_n = {sum[0], lo_q[W-1:1]};
        end
    end

    assign prod     = {hi_n, lo_n};
    assign prod_f   = sign_q ? -prod : prod;
    assign dv       = op_q[1] ? hi_n : lo_n;
    assign dv_f     = sign_q ? -dv : dv;
    assign calc_res = op_q[2] ? dv_f :
                      (op_q[1:0] == 2'b00) ? prod_f[W-1:0] : prod_f[2*W-1:W];

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: if (start_i && !flush_i) begin
                accept  = 1'b1;
                state_d = imm ? DONE : CALC;
            end
            CALC: if (flush_i) state_d = IDLE;
                  else if (cnt_q == COUNT_WIDTH'(1)) begin
                      fin     = 1'b1;
                      state_d = DONE;
                  end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op_i;
                hi_q  <= '0;
                cnt_q <= COUNT_WIDTH'(W);
                // Multiply keeps the multiplier in lo_q; divide shifts the dividend out of it
                lo_q  <= op_i[2] ? mag_a : mag_b;
                b_q   <= op_i[2] ? mag_b : mag_a;
                sign_q <= (op_i[2] && op_i[1]) ? neg_a : (neg_a ^ neg_b);
                if (imm) result_q <= imm_res;
            end else if (state_q == CALC && !flush_i) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q - COUNT_WIDTH'(1);
                if (fin) result_q <= calc_res;
            end
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
endmodule
